cache_fill_fsm: RTL and testbench

Miss-handling controller that drives the fill side of the direct-mapped cache. When the cache flags a miss, the block latches the missing block's base address and streams WORDS read requests to the multi-cycle main memory. It writes each returned word into the cache data array, then writes the tag/valid entry. It holds fsm_busy so the pipeline stalls until the line is resident.

---
 rtl/cache_fill_fsm.sv | 134 +++++++++++++
 tb/tb_cache_fill_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling controller for the fill side of a
// direct-mapped cache. On a miss it latches the block base address,
// streams WORDS read requests to main memory, writes each returned word
// into the data array, then writes the tag/valid entry. It stalls the
// pipeline (fsm_busy) until the line is resident.
module cache_fill_fsm #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss_detected,
    input  logic [ADDR_W-1:0]          miss_address,
    input  logic                       memory_data_valid,
    output logic                       mem_read_en,
    output logic [ADDR_W-1:0]          memory_address,
    output logic                       fsm_busy,
    output logic                       write_data_array,
    output logic                       write_tag_array,
    output logic [$clog2(WORDS)-1:0]   word_num,
    output logic [ADDR_W-1:0]          fill_address,
    output logic [15:0]                miss_count
);

    localparam int OFF_W = $clog2(WORDS);
    // Counters need one extra bit so they can hold the value WORDS itself.
    localparam int CNT_W = OFF_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]   rcv_cnt_q, rcv_cnt_d;
    logic [15:0]        miss_count_d;

    // Offsets OR'd into the block-aligned base; the low bits of base are
    // always zero, so this never carries into the tag/index bits.
    logic [ADDR_W-1:0]  req_addr;
    logic [ADDR_W-1:0]  rcv_addr;

    assign req_addr       = base_q | ADDR_W'(req_cnt_q[OFF_W-1:0]);
    assign rcv_addr       = base_q | ADDR_W'(rcv_cnt_q[OFF_W-1:0]);
    assign memory_address = req_addr;
    assign word_num       = rcv_cnt_q[OFF_W-1:0];

    // State, base address, request/return counters and miss counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            req_cnt_q  <= '0;
            rcv_cnt_q  <= '0;
            miss_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q    <= state_d;
            base_q     <= base_d;
            req_cnt_q  <= req_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
            miss_count <= miss_count_d;
        end
    end

    // Next-state logic and all fill-side strobes.
    always_comb begin
        // NOTE: every output and next-state value gets a default first so no
        // path through the case statement leaves one unassigned (no latches).
        state_d          = state_q;
        base_d           = base_q;
        req_cnt_d        = req_cnt_q;
        rcv_cnt_d        = rcv_cnt_q;
        miss_count_d     = miss_count;
        mem_read_en      = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_address     = miss_address;
        fsm_busy         = 1'b1;

        case (state_q)
            IDLE: begin
                // Stall in the same cycle the miss is seen; normal reads
                // pass their address straight through to the cache.
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    base_d       = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    req_cnt_d    = '0;
                    rcv_cnt_d    = '0;
                    miss_count_d = (miss_count == 16'hFFFF) ? miss_count
                                                            : miss_count + 16'd1;
                    state_d      = FILL;
                end
            end

            FILL: begin
                fill_address = rcv_addr;
                // Requests issue back to back, independent of returns.
                if (req_cnt_q < CNT_FULL) begin
                    mem_read_en = 1'b1;
                    req_cnt_d   = req_cnt_q + 1'b1;
                end
                // Returned word is written in the cycle it arrives.
                if (memory_data_valid && (rcv_cnt_q < CNT_FULL)) begin
                    write_data_array = 1'b1;
                    rcv_cnt_d        = rcv_cnt_q + 1'b1;
                    if (rcv_cnt_q == CNT_LAST) begin
                        state_d = TAG;
                    end
                end else if (rcv_cnt_q >= CNT_FULL) begin
                    state_d = TAG;
                end
            end

            TAG: begin
                // Single cycle: mark the line valid, then release the stall.
                write_tag_array = 1'b1;
                fill_address    = base_q;
                state_d         = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed sequence of misses with fixed-latency and
// randomly gapped memory returns, checked cycle by cycle against a
// transaction-level model of the fill protocol.
module tb_cache_fill_fsm;

    localparam int WORDS  = 8;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic              mem_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic              fsm_busy;
    logic              write_data_array;
    logic              write_tag_array;
    logic [2:0]        word_num;
    logic [ADDR_W-1:0] fill_address;
    logic [15:0]       miss_count;

    int checks   = 0;
    int failures = 0;
    int exp_misses = 0;

    cache_fill_fsm #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .fsm_busy          (fsm_busy),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .word_num          (word_num),
        .fill_address      (fill_address),
        .miss_count        (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bump_misses();
        if (exp_misses < 65535) exp_misses++;
    endtask

    // Outputs that must all be quiet after an asynchronous reset.
    task automatic check_reset_outputs(input string tag);
        check({tag, ".rd_en"},   32'(mem_read_en), 0);
        check({tag, ".wr_data"}, 32'(write_data_array), 0);
        check({tag, ".wr_tag"},  32'(write_tag_array), 0);
        check({tag, ".word"},    32'(word_num), 0);
        check({tag, ".maddr"},   32'(memory_address), 0);
        check({tag, ".count"},   32'(miss_count), 0);
        check({tag, ".busy"},    32'(fsm_busy), 0);
    endtask

    // One complete miss. lat>0: memory answers each request exactly lat
    // cycles later; lat==0: memory answers outstanding requests at random.
    // noise adds a valid in IDLE/TAG and a stray miss during FILL.
    // abort_after>0 asserts reset right after that many data writes.
    task automatic run_miss(input logic [ADDR_W-1:0] addr, input int lat,
                            input bit noise, input int abort_after);
        logic [ADDR_W-1:0] base;
        int writes;
        int issued;
        int cyc;
        bit v;
        base = (addr / WORDS) * WORDS;
        bump_misses();

        // Cycle 0: miss accepted in IDLE; a simultaneous valid is ignored.
        @(negedge clk);
        miss_detected     = 1'b1;
        miss_address      = addr;
        memory_data_valid = noise;
        #1;
        check("acc.busy",    32'(fsm_busy), 1);
        check("acc.rd_en",   32'(mem_read_en), 0);
        check("acc.wr_data", 32'(write_data_array), 0);
        check("acc.wr_tag",  32'(write_tag_array), 0);
        check("acc.faddr",   32'(fill_address), 32'(addr));
        @(posedge clk);

        writes = 0;
        issued = 0;
        cyc    = 1;
        while (writes < WORDS && cyc < 300) begin
            @(negedge clk);
            miss_detected = noise && (cyc == 3);
            miss_address  = noise ? 16'($urandom) : addr;
            if (lat > 0) v = (cyc - lat >= 1) && (cyc - lat <= WORDS);
            else         v = (issued > writes) && ($urandom_range(0, 2) != 0);
            memory_data_valid = v;
            #1;
            check("fill.busy",    32'(fsm_busy), 1);
            check("fill.rd_en",   32'(mem_read_en), 32'(cyc <= WORDS));
            if (cyc <= WORDS)
                check("fill.maddr", 32'(memory_address), 32'(base + 16'(cyc - 1)));
            check("fill.wr_data", 32'(write_data_array), 32'(v));
            check("fill.wr_tag",  32'(write_tag_array), 0);
            if (v) begin
                check("fill.word",  32'(word_num), 32'(writes));
                check("fill.faddr", 32'(fill_address), 32'(base + 16'(writes)));
            end
            if (cyc <= WORDS) issued++;
            if (v) writes++;
            if (abort_after > 0 && writes == abort_after) begin
                #2;
                rst = 1'b1;
                miss_detected = 1'b0;
                #1;
                exp_misses = 0;
                check_reset_outputs("abort");
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                memory_data_valid = 1'b0;
                return;
            end
            @(posedge clk);
            cyc++;
        end
        check("fill.timeout", 32'(writes), WORDS);

        // Tag cycle; a late valid here must not write.
        @(negedge clk);
        miss_detected     = 1'b0;
        miss_address      = addr;
        memory_data_valid = noise;
        #1;
        if (lat > 0) check("tag.cycle", 32'(cyc), 32'(WORDS + lat + 1));
        check("tag.wr_tag",  32'(write_tag_array), 1);
        check("tag.wr_data", 32'(write_data_array), 0);
        check("tag.rd_en",   32'(mem_read_en), 0);
        check("tag.faddr",   32'(fill_address), 32'(base));
        check("tag.busy",    32'(fsm_busy), 1);
        @(posedge clk);

        // Stall released; address passes through again.
        @(negedge clk);
        memory_data_valid = 1'b0;
        #1;
        check("done.busy",   32'(fsm_busy), 0);
        check("done.wr_tag", 32'(write_tag_array), 0);
        check("done.faddr",  32'(fill_address), 32'(addr));
        check("done.count",  32'(miss_count), 32'(exp_misses));
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = '0;
        memory_data_valid = 1'b0;
        // Before any clock edge: reset acts asynchronously.
        #3;
        check_reset_outputs("rst");
        check("rst.faddr", 32'(fill_address), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel.busy", 32'(fsm_busy), 0);

        // Directed miss with memory latency 4.
        run_miss(16'h1235, 4, 1'b0, 0);

        // A valid in IDLE with no miss writes nothing.
        @(negedge clk);
        memory_data_valid = 1'b1;
        miss_address      = 16'h4321;
        #1;
        check("idle.wr_data", 32'(write_data_array), 0);
        check("idle.busy",    32'(fsm_busy), 0);
        check("idle.faddr",   32'(fill_address), 32'h4321);
        @(negedge clk);
        memory_data_valid = 1'b0;

        // Irregular returns with stray valids and a stray miss.
        run_miss(16'h0A5F, 0, 1'b1, 0);
        // Top-of-memory block.
        run_miss(16'hFFFF, 3, 1'b0, 0);

        // Random misses, mixed memory behaviour.
        for (int i = 0; i < 6; i++) begin
            run_miss(16'($urandom), (i % 2 == 0) ? 0 : int'($urandom_range(1, 6)),
                     1'($urandom_range(0, 1)), 0);
        end

        // Reset after the third data write, then refill the same line.
        run_miss(16'h2468, 2, 1'b0, 3);
        run_miss(16'h2468, 2, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
